// File: rtl/prefetch_queue.sv
// ============================================================================
// Module   : prefetch_queue
// Brief    : Instruction prefetch FIFO between instruction memory and IF stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  input  logic        pop,
  output logic        imReq,
  output logic [15:0] imAddr,
  input  logic        imValid,
  input  logic [15:0] imData,
  output logic        valid,
  output logic [15:0] instruction,
  output logic [15:0] instrPC,
  output logic [3:0]  count
);

  localparam int         c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_DEPTH = 4'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_count;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [15:0]          r_fetch_pc;
  logic [15:0]          r_req_pc;
  logic [15:0]          r_instr_q [DEPTH];
  logic [15:0]          r_pc_q    [DEPTH];

  logic                 w_busy;
  logic                 w_push;
  logic                 w_pop_ok;
  logic [3:0]           w_slots;
  logic                 w_issue;

  assign w_busy   = (r_state == ST_BUSY);
  assign w_push   = reset && w_busy && imValid && !redirect;
  assign w_pop_ok = pop && (r_count != 4'd0);

  // Slots claimed after this cycle: stored entries minus the pop, plus the
  // response landing now in BUSY, which keeps a new request from overflowing.
  assign w_slots  = r_count - {3'b000, w_pop_ok} + {3'b000, w_busy};

  assign w_issue  = reset && !redirect &&
                    ((r_state == ST_IDLE) || (w_busy && imValid)) &&
                    (w_slots < c_DEPTH);

  assign imReq       = w_issue;
  assign imAddr      = r_fetch_pc;
  assign count       = r_count;
  assign valid       = (r_count != 4'd0);
  assign instruction = valid ? r_instr_q[r_rd_ptr] : 16'h0000;
  assign instrPC     = valid ? r_pc_q[r_rd_ptr]    : 16'h0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_count    <= 4'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 16'h0000;
    end else if (redirect) begin
      r_count    <= 4'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fetch_pc <= redirectPC;
      // A request still in flight must have its response dropped later.
      case (r_state)
        ST_BUSY:    r_state <= imValid ? ST_IDLE : ST_DISCARD;
        ST_DISCARD: r_state <= imValid ? ST_IDLE : ST_DISCARD;
        default:    r_state <= ST_IDLE;
      endcase
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= r_count + {3'b000, w_push} - {3'b000, w_pop_ok};
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 16'd2;
        r_req_pc   <= r_fetch_pc;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_issue) r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (imValid) r_state <= w_issue ? ST_BUSY : ST_IDLE;
        end
        ST_DISCARD: begin
          if (imValid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_wr_ptr] <= imData;
      r_pc_q[r_wr_ptr]    <= r_req_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prefetch_queue.sv
// ============================================================================
// Module   : tb_prefetch_queue
// Brief    : Directed bench for prefetch_queue with a variable-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirectPC = 16'h0000;
  logic        pop = 1'b0;
  logic        imReq;
  logic [15:0] imAddr;
  logic        imValid;
  logic [15:0] imData;
  logic        valid;
  logic [15:0] instruction;
  logic [15:0] instrPC;
  logic [3:0]  count;

  logic        resp_valid = 1'b0;
  logic [15:0] resp_data  = 16'h0000;
  logic        inj_valid  = 1'b0;
  logic [15:0] inj_data   = 16'h0000;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 1;
  int          n;
  logic [15:0] req_log [$];
  logic [15:0] exp_q   [$];

  assign imValid = resp_valid | inj_valid;
  assign imData  = inj_valid ? inj_data : resp_data;

  prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirectPC  (redirectPC),
    .pop         (pop),
    .imReq       (imReq),
    .imAddr      (imAddr),
    .imValid     (imValid),
    .imData      (imData),
    .valid       (valid),
    .instruction (instruction),
    .instrPC     (instrPC),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory: captures a request at posedge, answers lat cycles later.
  initial begin : p_memory
    logic        pend;
    logic [15:0] pend_addr;
    int          pend_cnt;
    pend = 1'b0;
    pend_addr = 16'h0000;
    pend_cnt = 0;
    forever begin
      @(posedge clk);
      if (reset && imReq) begin
        pend      = 1'b1;
        pend_addr = imAddr;
        pend_cnt  = lat;
        req_log.push_back(imAddr);
      end
      @(negedge clk);
      resp_valid = 1'b0;
      if (pend) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt <= 0) begin
          resp_valid = 1'b1;
          resp_data  = mem_word(pend_addr);
          pend       = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic load_exp(input logic [15:0] start);
    logic [15:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(a);
      a = a + 16'd2;
    end
  endtask

  // Compares the head against the scoreboard, then pops it.
  task automatic head_pop(input string tag);
    logic [15:0] e;
    check({tag, "_valid"}, 32'(valid), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    check({tag, "_pc"}, 32'(instrPC), 32'(e));
    check({tag, "_instr"}, 32'(instruction), 32'(mem_word(e)));
    pop = 1'b1;
  endtask

  function automatic logic [15:0] log_at(input int idx);
    if (idx < req_log.size()) return req_log[idx];
    return 16'hxxxx;
  endfunction

  initial begin : p_main
    #2 reset = 1'b0;
    cyc(2);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_pc", 32'(instrPC), 32'd0);
    check("rst_imreq", 32'(imReq), 32'd0);

    // Fill from reset with 1-cycle memory and no pops.
    reset = 1'b1;
    load_exp(16'h0000);
    cyc(8);
    check("fill_reqs", 32'(req_log.size()), 32'd4);
    check("fill_req0", 32'(log_at(0)), 32'h0000);
    check("fill_req1", 32'(log_at(1)), 32'h0002);
    check("fill_req2", 32'(log_at(2)), 32'h0004);
    check("fill_req3", 32'(log_at(3)), 32'h0006);
    check("fill_count", 32'(count), 32'd4);
    check("fill_pc", 32'(instrPC), 32'h0000);

    // Single pop from a full queue.
    head_pop("pop1");
    @(negedge clk);
    pop = 1'b0;
    check("pop1_count", 32'(count), 32'd3);
    check("pop1_pc", 32'(instrPC), 32'h0002);
    cyc(3);
    check("pop1_refill", 32'(count), 32'd4);
    check("pop1_reqs", 32'(req_log.size()), 32'd5);
    check("pop1_addr", 32'(log_at(4)), 32'h0008);

    // Steady pop every cycle: one entry per cycle, no gaps.
    for (int i = 0; i < 20; i++) begin
      head_pop("steady");
      @(negedge clk);
    end
    pop = 1'b0;
    cyc(4);
    check("steady_full", 32'(count), 32'd4);

    // Redirect while BUSY, response arrives the following cycle.
    lat = 2;
    head_pop("pre_redir");
    @(negedge clk);
    pop = 1'b0;
    n = req_log.size();
    redirect = 1'b1;
    redirectPC = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    load_exp(16'h0040);
    check("redir_count", 32'(count), 32'd0);
    check("redir_valid", 32'(valid), 32'd0);
    check("redir_instr", 32'(instruction), 32'd0);
    check("redir_pc", 32'(instrPC), 32'd0);
    @(negedge clk);
    check("discard_count", 32'(count), 32'd0);
    check("discard_noreq", 32'(req_log.size()), 32'(n));
    @(negedge clk);
    check("redir_addr", 32'(log_at(n)), 32'h0040);
    cyc(15);
    check("redir_fill", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      head_pop("redir_seq");
      @(negedge clk);
    end
    pop = 1'b0;
    cyc(14);

    // Redirect in the same cycle as the response.
    lat = 1;
    cyc(2);
    head_pop("pre_redir2");
    @(negedge clk);
    pop = 1'b0;
    n = req_log.size();
    redirect = 1'b1;
    redirectPC = 16'h0100;
    @(negedge clk);
    redirect = 1'b0;
    load_exp(16'h0100);
    check("redir2_count", 32'(count), 32'd0);
    check("redir2_noreq", 32'(req_log.size()), 32'(n));
    @(negedge clk);
    check("redir2_addr", 32'(log_at(n)), 32'h0100);
    cyc(6);
    check("redir2_fill", 32'(count), 32'd4);
    for (int i = 0; i < 2; i++) begin
      head_pop("redir2_seq");
      @(negedge clk);
    end
    pop = 1'b0;
    cyc(8);

    // Wrap of fetch address, plus a pop against an empty queue.
    n = req_log.size();
    redirect = 1'b1;
    redirectPC = 16'hFFFC;
    @(negedge clk);
    redirect = 1'b0;
    load_exp(16'hFFFC);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    check("empty_pop_count", 32'(count), 32'd0);
    check("empty_pop_valid", 32'(valid), 32'd0);
    check("empty_pop_pc", 32'(instrPC), 32'd0);
    cyc(8);
    check("wrap_req0", 32'(log_at(n)), 32'hFFFC);
    check("wrap_req1", 32'(log_at(n + 1)), 32'hFFFE);
    check("wrap_req2", 32'(log_at(n + 2)), 32'h0000);
    check("wrap_req3", 32'(log_at(n + 3)), 32'h0002);
    check("wrap_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      head_pop("wrap_seq");
      @(negedge clk);
    end
    pop = 1'b0;
    cyc(8);

    // Stray imValid while IDLE with a full queue.
    n = req_log.size();
    inj_valid = 1'b1;
    inj_data = 16'hDEAD;
    @(negedge clk);
    inj_valid = 1'b0;
    check("idle_valid_count", 32'(count), 32'd4);
    check("idle_valid_noreq", 32'(req_log.size()), 32'(n));
    head_pop("idle_valid_head");
    @(negedge clk);
    pop = 1'b0;
    cyc(4);

    // Reset while a request is outstanding.
    lat = 2;
    head_pop("pre_reset");
    @(negedge clk);
    pop = 1'b0;
    reset = 1'b0;
    #1;
    check("areset_count", 32'(count), 32'd0);
    check("areset_valid", 32'(valid), 32'd0);
    check("areset_pc", 32'(instrPC), 32'd0);
    check("areset_imreq", 32'(imReq), 32'd0);
    cyc(3);
    reset = 1'b1;
    n = req_log.size();
    load_exp(16'h0000);
    cyc(14);
    check("rerun_addr", 32'(log_at(n)), 32'h0000);
    check("rerun_count", 32'(count), 32'd4);
    head_pop("rerun_head");
    @(negedge clk);
    pop = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
